// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four parallel channels from a 4-slot TDM stream.
// A 2-bit slot counter is aligned by frame_sync. Slots 0..2 are held in
// shadow registers. The slot-3 beat moves the whole frame to A..D at once.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   din, din_valid   - TDM sample and its one-beat qualifier
//   frame_sync       - marks a valid beat as slot 0
//   A, B, C, D       - registered channel outputs (slots 00..11)
//   S                - slot index the next valid beat is written to
//   frame_valid      - one-cycle pulse after A..D take a complete frame
//   sync_err         - one-cycle pulse after frame_sync arrives off slot 0
//   locked           - high once aligned to a frame_sync
module tdm_demux4 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   input  logic         frame_sync,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic [W-1:0] D,
   output logic [1:0]   S,
   output logic         frame_valid,
   output logic         sync_err,
   output logic         locked
);

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [1:0]   s_q, s_d;
   logic [W-1:0] sh0_q, sh1_q, sh2_q;
   logic [W-1:0] sh0_d, sh1_d, sh2_d;
   logic [W-1:0] a_q, b_q, c_q, d_q;
   logic [W-1:0] a_d, b_d, c_d, d_d;
   logic         fv_q, fv_d;
   logic         se_q, se_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNLOCKED;
         s_q     <= 2'd0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         fv_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         fv_q    <= fv_d;
         se_q    <= se_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      fv_d    = 1'b0;
      se_d    = 1'b0;

      if (din_valid) begin
         case (state_q)
            ST_UNLOCKED: begin
               // Beats before the first marker carry no slot position
               if (frame_sync) begin
                  sh0_d   = din;
                  s_d     = 2'd1;
                  state_d = ST_LOCKED;
               end
            end
            default: begin
               if (frame_sync && (s_q != 2'd0)) begin
                  // Realign: drop the partial frame, this beat becomes slot 0
                  se_d  = 1'b1;
                  sh0_d = din;
                  s_d   = 2'd1;
               end else begin
                  case (s_q)
                     2'd0: sh0_d = din;
                     2'd1: sh1_d = din;
                     2'd2: sh2_d = din;
                     default: begin
                        a_d  = sh0_q;
                        b_d  = sh1_q;
                        c_d  = sh2_q;
                        d_d  = din;
                        fv_d = 1'b1;
                     end
                  endcase
                  s_d = s_q + 2'd1;
               end
            end
         endcase
      end
   end

   assign A           = a_q;
   assign B           = b_q;
   assign C           = c_q;
   assign D           = d_q;
   assign S           = s_q;
   assign frame_valid = fv_q;
   assign sync_err    = se_q;
   assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4, one W=1 and one W=4 instance.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [0:0] din1 = '0;
   logic       dv1  = 1'b0;
   logic       fs1  = 1'b0;
   logic [0:0] a1, b1, c1, d1;
   logic [1:0] s1;
   logic       fv1, se1, lk1;

   logic [3:0] din4 = '0;
   logic       dv4  = 1'b0;
   logic       fs4  = 1'b0;
   logic [3:0] a4, b4, c4, d4;
   logic [1:0] s4;
   logic       fv4, se4, lk4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tdm_demux4 #(.W(1)) u_dut1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .frame_sync(fs1),
      .A(a1), .B(b1), .C(c1), .D(d1), .S(s1),
      .frame_valid(fv1), .sync_err(se1), .locked(lk1)
   );

   tdm_demux4 #(.W(4)) u_dut4 (
      .clk(clk), .rst(rst), .din(din4), .din_valid(dv4), .frame_sync(fs4),
      .A(a4), .B(b4), .C(c4), .D(d4), .S(s4),
      .frame_valid(fv4), .sync_err(se4), .locked(lk4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pack A..D of the W=1 instance as {A,B,C,D}
   function automatic logic [31:0] abcd1();
      return {28'd0, a1, b1, c1, d1};
   endfunction

   task automatic beat1(input logic d, input logic fs);
      din1 = d;
      fs1  = fs;
      dv1  = 1'b1;
      tick();
      dv1  = 1'b0;
      fs1  = 1'b0;
   endtask

   task automatic beat4(input logic [3:0] d, input logic fs);
      din4 = d;
      fs4  = fs;
      dv4  = 1'b1;
      tick();
      dv4  = 1'b0;
      fs4  = 1'b0;
   endtask

   initial begin
      // Reset then aligned frame
      rst = 1'b1;
      tick();
      tick();
      chk("rst_abcd", abcd1(), 32'h0);
      chk("rst_s", 32'(s1), 32'd0);
      chk("rst_fv", 32'(fv1), 32'd0);
      chk("rst_se", 32'(se1), 32'd0);
      chk("rst_locked", 32'(lk1), 32'd0);
      rst = 1'b0;
      beat1(1'b1, 1'b1);
      chk("t1_s1", 32'(s1), 32'd1);
      chk("t1_locked", 32'(lk1), 32'd1);
      beat1(1'b0, 1'b0);
      chk("t1_s2", 32'(s1), 32'd2);
      beat1(1'b1, 1'b0);
      chk("t1_s3", 32'(s1), 32'd3);
      chk("t1_fv_early", 32'(fv1), 32'd0);
      chk("t1_abcd_early", abcd1(), 32'h0);
      beat1(1'b0, 1'b0);
      chk("t1_abcd", abcd1(), 32'hA);
      chk("t1_fv", 32'(fv1), 32'd1);
      chk("t1_s0", 32'(s1), 32'd0);
      tick();
      chk("t1_fv_drop", 32'(fv1), 32'd0);
      chk("t1_abcd_hold", abcd1(), 32'hA);

      // Pre-lock discard
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat1(1'b1, 1'b0);
         chk("t2_unl_s", 32'(s1), 32'd0);
         chk("t2_unl_locked", 32'(lk1), 32'd0);
      end
      beat1(1'b0, 1'b1);
      beat1(1'b1, 1'b0);
      beat1(1'b1, 1'b0);
      chk("t2_fv_early", 32'(fv1), 32'd0);
      beat1(1'b0, 1'b0);
      chk("t2_abcd", abcd1(), 32'h6);
      chk("t2_fv", 32'(fv1), 32'd1);
      tick();
      chk("t2_fv_drop", 32'(fv1), 32'd0);

      // Gapped frame; frame_sync with din_valid=0 must be ignored
      beat1(1'b1, 1'b1);
      fs1 = 1'b1;
      tick();
      fs1 = 1'b0;
      tick();
      chk("t3_gap_s", 32'(s1), 32'd1);
      chk("t3_gap_se", 32'(se1), 32'd0);
      beat1(1'b1, 1'b0);
      tick();
      tick();
      chk("t3_gap_s2", 32'(s1), 32'd2);
      beat1(1'b0, 1'b0);
      tick();
      tick();
      chk("t3_gap_s3", 32'(s1), 32'd3);
      chk("t3_gap_fv", 32'(fv1), 32'd0);
      chk("t3_gap_abcd", abcd1(), 32'h6);
      beat1(1'b0, 1'b0);
      chk("t3_abcd", abcd1(), 32'hC);
      chk("t3_fv", 32'(fv1), 32'd1);
      tick();
      chk("t3_fv_drop", 32'(fv1), 32'd0);

      // Misalignment
      beat1(1'b1, 1'b1);
      beat1(1'b0, 1'b0);
      beat1(1'b0, 1'b1);
      chk("t4_se", 32'(se1), 32'd1);
      chk("t4_fv", 32'(fv1), 32'd0);
      chk("t4_s", 32'(s1), 32'd1);
      chk("t4_locked", 32'(lk1), 32'd1);
      chk("t4_abcd_hold", abcd1(), 32'hC);
      beat1(1'b1, 1'b0);
      chk("t4_se_drop", 32'(se1), 32'd0);
      beat1(1'b1, 1'b0);
      beat1(1'b1, 1'b0);
      chk("t4_abcd", abcd1(), 32'h7);
      chk("t4_fv2", 32'(fv1), 32'd1);
      chk("t4_se2", 32'(se1), 32'd0);

      // Reset mid-frame
      beat1(1'b1, 1'b1);
      beat1(1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_abcd", abcd1(), 32'h0);
      chk("t5_s", 32'(s1), 32'd0);
      chk("t5_locked", 32'(lk1), 32'd0);
      beat1(1'b1, 1'b1);
      beat1(1'b1, 1'b0);
      beat1(1'b0, 1'b0);
      beat1(1'b1, 1'b0);
      chk("t5_abcd2", abcd1(), 32'hD);
      chk("t5_fv", 32'(fv1), 32'd1);

      // Streaming, W=4: three frames back-to-back
      chk("t6_locked0", 32'(lk4), 32'd0);
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 4; k++) begin
            beat4(4'(4 * f + k + 1), (k == 0));
            chk("t6_se", 32'(se4), 32'd0);
            if (k == 3) begin
               chk("t6_fv", 32'(fv4), 32'd1);
               chk("t6_a", 32'(a4), 32'(4 * f + 1));
               chk("t6_b", 32'(b4), 32'(4 * f + 2));
               chk("t6_c", 32'(c4), 32'(4 * f + 3));
               chk("t6_d", 32'(d4), 32'(4 * f + 4));
            end else begin
               chk("t6_fv_low", 32'(fv4), 32'd0);
            end
         end
      end
      tick();
      chk("t6_fv_drop", 32'(fv4), 32'd0);
      chk("t6_hold", {16'd0, a4, b4, c4, d4}, 32'h9ABC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
